// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings and LSU state type, plus small width-decode helpers.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // funct3[1:0] encodes access width for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic lsu_fault(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] off);
    logic bad_code;
    bad_code = 1'b0;
    if (ld) begin
      case (f3)
        lb, lh, lw, lbu, lhu: bad_code = 1'b0;
        default:              bad_code = 1'b1;
      endcase
    end else begin
      case (f3)
        sb, sh, sw: bad_code = 1'b0;
        default:    bad_code = 1'b1;
      endcase
    end
    return (ld == st) || bad_code ||
           ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed lane of a D-cache read word and sign/zero-extends it per load width.
module load_aligner
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [31:0] lane;
  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      lb:      result = {{24{lane[7]}}, lane[7:0]};
      lh:      result = {{16{lane[15]}}, lane[15:0]};
      lw:      result = rdata;
      lbu:     result = {24'h0, lane[7:0]};
      lhu:     result = {16'h0, lane[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: captures one request, runs a single D-cache transaction, pulses done.
module load_store_unit
  import rv32i_types::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        wait_timeout,
  output logic        d_mem_read,
  output logic        d_mem_write,
  output logic [31:0] d_mem_address,
  output logic [3:0]  d_mem_byte_en,
  output logic [31:0] d_mem_wdata,
  input  logic        d_mem_resp,
  input  logic [31:0] d_mem_rdata,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_t  state;
  logic        r_is_load;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_store_data;
  logic [CW-1:0] wait_cnt;
  logic [31:0] aligned;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is gated by rst so nothing is accepted while reset is held.
  assign req_ready = (state == IDLE) && !rst;
  assign state_dbg = state;

  // Strobes follow the state register directly, so an async reset drops them immediately.
  assign d_mem_read    = (state == REQ) && r_is_load;
  assign d_mem_write   = (state == REQ) && r_is_store;
  assign d_mem_address = {r_addr[31:2], 2'b00};
  assign d_mem_byte_en = lane_enables(r_funct3, r_addr[1:0]);

  always_comb begin
    d_mem_wdata = r_store_data;
    case (r_funct3[1:0])
      2'b00:   d_mem_wdata = {4{r_store_data[7:0]}};
      2'b01:   d_mem_wdata = {2{r_store_data[15:0]}};
      default: d_mem_wdata = r_store_data;
    endcase
  end

  load_aligner u_load_aligner (
    .rdata  (d_mem_rdata),
    .funct3 (r_funct3),
    .offset (r_addr[1:0]),
    .result (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_store_data <= '0;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      load_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_is_load    <= is_load;
            r_is_store   <= is_store;
            r_funct3     <= funct3;
            r_addr       <= addr;
            r_store_data <= store_data;
            if (lsu_fault(is_load, is_store, funct3, addr[1:0])) begin
              state     <= DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              load_data <= '0;
            end else begin
              state    <= REQ;
              wait_cnt <= '0;
            end
          end
        end
        REQ: begin
          if (d_mem_resp) begin
            state     <= DONE;
            done      <= 1'b1;
            load_data <= r_is_load ? aligned : 32'h0;
          end else if (wait_cnt != CW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(MAX_WAIT - 1)) wait_timeout <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          fault     <= 1'b0;
          load_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: hand-computed vector table, randomized ops against a reference model,
// and directed sequences for the watchdog, reset-during-request and DONE-state corner cases.
module tb_load_store_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        done, fault, wait_timeout;
  logic [31:0] load_data;
  logic        d_mem_read, d_mem_write, d_mem_resp;
  logic [31:0] d_mem_address, d_mem_wdata, d_mem_rdata;
  logic [3:0]  d_mem_byte_en;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        il;
    logic        is;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic        e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
  } vec_t;

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .is_load       (is_load),
    .is_store      (is_store),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .done          (done),
    .load_data     (load_data),
    .fault         (fault),
    .wait_timeout  (wait_timeout),
    .d_mem_read    (d_mem_read),
    .d_mem_write   (d_mem_write),
    .d_mem_address (d_mem_address),
    .d_mem_byte_en (d_mem_byte_en),
    .d_mem_wdata   (d_mem_wdata),
    .d_mem_resp    (d_mem_resp),
    .d_mem_rdata   (d_mem_rdata),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic il, input logic is, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int dl, input logic ef, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.il = il; v.is = is; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.delay = dl; v.e_fault = ef; v.e_be = be; v.e_wdata = wd; v.e_ld = ld;
    return v;
  endfunction

  // Reference model: decodes the operation arithmetically from the ISA rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int off, w;
    logic [31:0] lane, b, h;
    r = v;
    off = int'(v.addr % 4);
    w = int'(v.f3 % 4);
    lane = v.rdata >> (8 * off);
    r.e_fault = (v.il == v.is) ||
                (v.il && (v.f3 == 3 || v.f3 == 6 || v.f3 == 7)) ||
                (v.is && v.f3 > 2) ||
                (w == 1 && (v.addr % 2) != 0) ||
                (w == 2 && off != 0);
    r.e_be = (w == 0) ? 4'(1 << off) : (w == 1) ? 4'(3 << off) : 4'hF;
    if (w == 0)      r.e_wdata = (v.sdata % 256) * 32'h0101_0101;
    else if (w == 1) r.e_wdata = (v.sdata % 65536) * 32'h0001_0001;
    else             r.e_wdata = v.sdata;
    b = lane % 256;
    h = lane % 65536;
    r.e_ld = 0;
    if (v.il && !r.e_fault) begin
      case (v.f3)
        3'd0:    r.e_ld = (b >= 128) ? b - 256 : b;
        3'd1:    r.e_ld = (h >= 32768) ? h - 65536 : h;
        3'd2:    r.e_ld = v.rdata;
        3'd4:    r.e_ld = b;
        3'd5:    r.e_ld = h;
        default: r.e_ld = 0;
      endcase
    end
    return r;
  endfunction

  // driver: issue one op, answer the D-cache after v.delay waiting cycles, check everything
  task automatic run_vec(input vec_t v, input string tag);
    logic seen_rd, seen_wr, both, got_done, got_fault, any_strobe;
    logic [31:0] got_ld, s_addr, s_wd;
    logic [3:0]  s_be;
    int lat, n;
    seen_rd = 0; seen_wr = 0; both = 0; got_done = 0; got_fault = 0; any_strobe = 0;
    got_ld = 0; s_addr = 0; s_wd = 0; s_be = 0; lat = 0; n = 0;
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 1);
    req_valid = 1; is_load = v.il; is_store = v.is; funct3 = v.f3;
    addr = v.addr; store_data = v.sdata;
    @(negedge clk);
    req_valid = 0; is_load = 0; is_store = 0; addr = $urandom; store_data = $urandom;
    for (int c = 0; c < 64 && !got_done; c++) begin
      if (done) begin
        got_done = 1; lat = c + 1; got_fault = fault; got_ld = load_data;
      end else begin
        if (d_mem_read || d_mem_write) begin
          any_strobe = 1;
          if (d_mem_read && d_mem_write) both = 1;
          if (n == 0) begin seen_rd = d_mem_read; seen_wr = d_mem_write; end
          if (n == v.delay) begin
            s_addr = d_mem_address; s_be = d_mem_byte_en; s_wd = d_mem_wdata;
            d_mem_resp = 1; d_mem_rdata = v.rdata;
          end
          n++;
        end
        @(negedge clk);
        d_mem_resp = 0; d_mem_rdata = $urandom;
      end
    end
    check({tag, " latency"}, lat, v.e_fault ? 1 : v.delay + 2);
    check({tag, " fault"}, 32'(got_fault), 32'(v.e_fault));
    check({tag, " load_data"}, got_ld, v.e_ld);
    if (v.e_fault) begin
      check({tag, " no_strobe"}, 32'(any_strobe), 0);
    end else begin
      check({tag, " rd_strobe"}, 32'(seen_rd), 32'(v.il));
      check({tag, " wr_strobe"}, 32'(seen_wr), 32'(v.is));
      check({tag, " both_strobes"}, 32'(both), 0);
      check({tag, " address"}, s_addr, {v.addr[31:2], 2'b00});
      check({tag, " byte_en"}, 32'(s_be), 32'(v.e_be));
      if (v.is) check({tag, " wdata"}, s_wd, v.e_wdata);
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done), 0);
  endtask

  vec_t tbl[14];

  initial begin
    vec_t v;
    int r;
    rst = 1; req_valid = 0; is_load = 0; is_store = 0; funct3 = 0;
    addr = 0; store_data = 0; d_mem_resp = 0; d_mem_rdata = 0;

    // reset state
    #12;
    check("rst ready", 32'(req_ready), 0);
    check("rst state", 32'(state_dbg), 32'(IDLE));
    check("rst done", 32'(done), 0);
    check("rst strobes", 32'({d_mem_read, d_mem_write}), 0);
    check("rst load_data", load_data, 0);
    check("rst timeout", 32'(wait_timeout), 0);
    @(negedge clk); rst = 0;
    #1 check("post_rst ready", 32'(req_ready), 1);

    //            il  is  f3      addr          sdata         rdata        dl fault be       wdata         ld
    tbl[0]  = mk(1, 0, 3'b000, 32'h1003, 0,             32'h80FF_FF7F, 3, 0, 4'b1000, 0,             32'hFFFF_FF80);
    tbl[1]  = mk(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 0,             0, 0, 4'b1100, 32'hABCD_ABCD, 0);
    tbl[2]  = mk(1, 0, 3'b010, 32'h3001, 0,             32'h5555_5555, 0, 1, 4'b1111, 0,             0);
    tbl[3]  = mk(1, 0, 3'b100, 32'h1001, 0,             32'h1122_8344, 1, 0, 4'b0010, 0,             32'h0000_0083);
    tbl[4]  = mk(1, 0, 3'b001, 32'h1000, 0,             32'h0000_F00F, 0, 0, 4'b0011, 0,             32'hFFFF_F00F);
    tbl[5]  = mk(1, 0, 3'b010, 32'h2004, 0,             32'hDEAD_BEEF, 2, 0, 4'b1111, 0,             32'hDEAD_BEEF);
    tbl[6]  = mk(0, 1, 3'b000, 32'h0002, 32'h0000_00A5, 0,             0, 0, 4'b0100, 32'hA5A5_A5A5, 0);
    tbl[7]  = mk(0, 1, 3'b010, 32'h0008, 32'hCAFE_F00D, 0,             2, 0, 4'b1111, 32'hCAFE_F00D, 0);
    tbl[8]  = mk(1, 1, 3'b000, 32'h0000, 0,             0,             0, 1, 4'b0001, 0,             0);
    tbl[9]  = mk(0, 0, 3'b000, 32'h0000, 0,             0,             0, 1, 4'b0001, 0,             0);
    tbl[10] = mk(1, 0, 3'b011, 32'h0000, 0,             0,             0, 1, 4'b1111, 0,             0);
    tbl[11] = mk(0, 1, 3'b100, 32'h0000, 0,             0,             0, 1, 4'b0001, 0,             0);
    tbl[12] = mk(0, 1, 3'b001, 32'h0001, 32'h0000_BEEF, 0,             0, 1, 4'b0110, 0,             0);
    tbl[13] = mk(1, 0, 3'b101, 32'h0002, 0,             32'h8001_0000, 1, 0, 4'b1100, 0,             32'h0000_8001);
    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // randomized ops against the model, delays kept below the watchdog limit
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      v.il = (r < 4) || (r == 8);
      v.is = (r >= 4 && r < 8) || (r == 8);
      v.f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.sdata = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 3);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end
    check("no_early_timeout", 32'(wait_timeout), 0);

    // watchdog: lhu waits 6 cycles, flag must rise after the 4th waiting cycle
    @(negedge clk);
    req_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b101; addr = 32'h4002;
    @(negedge clk);
    req_valid = 0; is_load = 0;
    for (int n = 0; n <= 6; n++) begin
      check($sformatf("wd read_held%0d", n), 32'(d_mem_read), 1);
      check($sformatf("wd flag%0d", n), 32'(wait_timeout), 32'(n >= 4));
      if (n == 6) begin d_mem_resp = 1; d_mem_rdata = 32'h8001_0000; end
      @(negedge clk);
      d_mem_resp = 0;
    end
    check("wd done", 32'(done), 1);
    check("wd load_data", load_data, 32'h0000_8001);
    @(negedge clk);
    check("wd sticky", 32'(wait_timeout), 1);

    // req_valid held through DONE is ignored; accepted again only from IDLE
    @(negedge clk);
    req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h3001;
    @(negedge clk);
    check("hold done1", 32'(done), 1);
    check("hold fault1", 32'(fault), 1);
    @(negedge clk);
    check("hold idle_gap", 32'(done), 0);
    check("hold idle_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("hold done2", 32'(done), 1);
    req_valid = 0; is_load = 0;
    @(negedge clk);

    // stray response in IDLE does nothing
    d_mem_resp = 1;
    @(negedge clk);
    @(negedge clk);
    check("stray done", 32'(done), 0);
    check("stray state", 32'(state_dbg), 32'(IDLE));
    d_mem_resp = 0;

    // reset in the middle of a store request
    @(negedge clk);
    req_valid = 1; is_store = 1; funct3 = 3'b010; addr = 32'h5000; store_data = 32'h1111_1111;
    @(negedge clk);
    req_valid = 0; is_store = 0;
    check("mid_rst write_before", 32'(d_mem_write), 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst write_drop", 32'(d_mem_write), 0);
    check("mid_rst state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst ready", 32'(req_ready), 0);
    check("mid_rst timeout_clear", 32'(wait_timeout), 0);
    @(negedge clk);
    rst = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("mid_rst no_done%0d", n), 32'(done), 0);
    end
    check("mid_rst ready_after", 32'(req_ready), 1);
    run_vec(mk(0, 1, 3'b010, 32'h5000, 32'h2222_3333, 0, 1, 0, 4'b1111, 32'h2222_3333, 0), "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
